// File: rtl/irda_wb_pkg.sv
// Shared types and constants for the IrDA Wishbone mode router.
// Holds the router FSM encoding, the protocol-engine mode numbers and the default bus widths.
package irda_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } wb_state_e;

  localparam int MODE_SIR = 0;
  localparam int MODE_MIR = 1;
  localparam int MODE_FIR = 2;

  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_AW = 4;

endpackage

// File: rtl/irda_wb_timeout.sv
// Bus-cycle timeout counter with a one-cycle expiry pulse.
// The whole module exists only when IRDA_WB_ROUTER_TIMEOUT_EN is defined.
`ifdef IRDA_WB_ROUTER_TIMEOUT_EN
module irda_wb_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNTW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNTW-1:0] count_r;

  // Count enabled cycles; clear has priority so a finished cycle restarts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNTW{1'b0}};
    end else if (clr) begin
      count_r <= {CNTW{1'b0}};
    end else if (en) begin
      count_r <= count_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en & ~clr & (count_r == CNTW'(LIMIT - 1));

endmodule
`endif

// File: rtl/irda_wb_mode_router.sv
// Wishbone slave fan-out to NCH IrDA protocol engines, with a mode register that moves only between cycles.
// Optional bus-timeout abort is built when IRDA_WB_ROUTER_TIMEOUT_EN is defined.
module irda_wb_mode_router
  import irda_wb_pkg::*;
#(
  parameter int             NCH        = 2,
  parameter int             DW         = DEFAULT_DW,
  parameter int             AW         = DEFAULT_AW,
  parameter logic [NCH-1:0] WP_MASK    = {1'b1, {(NCH-1){1'b0}}},
  parameter int             TIMEOUT    = 16,
  parameter int             RESET_MODE = MODE_SIR,
  localparam int            CW         = $clog2(NCH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [CW-1:0]     mode_sel_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [AW-1:0]     wb_adr_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [NCH-1:0]    s_cyc_o,
  output logic [NCH-1:0]    s_stb_o,
  output logic [NCH-1:0]    s_we_o,
  output logic [NCH*DW-1:0] s_dat_o,
  output logic [NCH*AW-1:0] s_adr_o,
  input  logic [NCH-1:0]    s_ack_i,
  input  logic [NCH*DW-1:0] s_dat_i,
  output logic [CW-1:0]     mode_o,
  output logic              busy_o
);

  wb_state_e     state_r, state_nxt_s;
  logic [CW-1:0] mode_r;
  logic          ack_sel_s;
  logic [DW-1:0] dat_sel_s;
  logic          abort_s;
  logic          ack_s;
  logic          expire_s;
  logic          mode_legal_s;

  assign abort_s      = (state_r == ST_ABORT);
  assign mode_legal_s = ({1'b0, mode_sel_i} < (CW+1)'(NCH));

  // Mode register: only sampled while idle with no cycle open.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mode_r <= CW'(RESET_MODE);
    end else if ((state_r == ST_IDLE) && !wb_cyc_i && mode_legal_s) begin
      mode_r <= mode_sel_i;
    end else begin
      mode_r <= mode_r;
    end
  end

  // Fan the master out to the selected channel and pick its reply.
  always_comb begin
    s_cyc_o   = {NCH{1'b0}};
    s_stb_o   = {NCH{1'b0}};
    s_we_o    = {NCH{1'b0}};
    s_dat_o   = {(NCH*DW){1'b0}};
    s_adr_o   = {(NCH*AW){1'b0}};
    ack_sel_s = 1'b0;
    dat_sel_s = {DW{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      if (mode_r == CW'(c)) begin
        s_cyc_o[c]           = wb_cyc_i & ~abort_s;
        s_stb_o[c]           = wb_stb_i & ~abort_s;
        s_we_o[c]            = wb_we_i & ~(WP_MASK[c] & wb_adr_i[AW-1]);
        s_dat_o[c*DW +: DW]  = wb_dat_i;
        s_adr_o[c*AW +: AW]  = wb_adr_i;
        ack_sel_s            = s_ack_i[c];
        dat_sel_s            = s_dat_i[c*DW +: DW];
      end else begin
        s_cyc_o[c]           = 1'b0;
        s_stb_o[c]           = 1'b0;
        s_we_o[c]            = 1'b0;
        s_dat_o[c*DW +: DW]  = {DW{1'b0}};
        s_adr_o[c*AW +: AW]  = {AW{1'b0}};
      end
    end
  end

  // Late slave acks during an abort must never reach the master.
  assign ack_s = ack_sel_s & wb_cyc_i & wb_stb_i & ~abort_s;

`ifdef IRDA_WB_ROUTER_TIMEOUT_EN
  irda_wb_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    ((state_r != ST_ACTIVE) | ack_s),
    .en     (state_r == ST_ACTIVE),
    .expire (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: an ack always wins over a same-cycle timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ack_s || !wb_cyc_i) begin
          state_nxt_s = ST_IDLE;
        end else if (expire_s) begin
          state_nxt_s = ST_ABORT;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_ABORT: begin
        if (!wb_cyc_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ABORT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign wb_ack_o = ack_s;
  assign wb_dat_o = dat_sel_s;
  assign wb_err_o = expire_s & ~ack_s;
  assign mode_o   = mode_r;
  assign busy_o   = (state_r != ST_IDLE);

endmodule

// File: doc/irda_wb_mode_router.md
# irda_wb_mode_router

Parametrised Wishbone slave-side router for the IrDA core: fans a single Wishbone slave port out to NCH protocol engines (SIR UART, MIR, FIR, …) and muxes their replies back. The active channel is held in a register that changes only between bus cycles, so a mode change can never split a transfer. Per-channel write protection, cycle tracking and an optional bus-timeout abort are added on top of the plain mux. Sits between the system Wishbone interconnect and the per-mode engines inside the IrDA top level.

## Interface
- NCH, 2: number of downstream channels (2..8)
- DW, 32: data width, master and slave sides
- AW, 4: address width
- WP_MASK, 'b10…0 = 1 << (NCH-1): bit c set → writes to channel c with wb_adr_i[AW-1]=1 are forced to reads
- TIMEOUT, 16: cycles without ack before abort (≥2; used only with the timeout feature)
- RESET_MODE, 0: channel selected after reset

- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- mode_sel_i  in  CW=$clog2(NCH)  requested channel
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  master strobes
- wb_dat_i  in  DW;  wb_adr_i  in  AW
- wb_ack_o  out  1;  wb_err_o  out  1;  wb_dat_o  out  DW
- s_cyc_o, s_stb_o, s_we_o  out  NCH  per-channel strobes
- s_dat_o  out  NCH*DW;  s_adr_o  out  NCH*AW  (flattened, channel c at [c*W +: W])
- s_ack_i  in  NCH;  s_dat_i  in  NCH*DW
- mode_o  out  CW  active channel;  busy_o  out  1  cycle in flight

## Operation
- Register mode_q; all routing uses mode_q, never mode_sel_i directly.
- Channel c = mode_q: s_cyc/stb/dat/adr = master values; s_we = wb_we_i & ~(WP_MASK[c] & wb_adr_i[AW-1]). All other channels: every output zero.
- wb_ack_o = s_ack_i[mode_q] & wb_cyc_i & wb_stb_i; wb_dat_o = s_dat_i[mode_q] (pass-through, combinational).
- mode_sel_i ≥ NCH: ignored, mode_q unchanged.
- FSM states IDLE, ACTIVE, ABORT:
  - IDLE: wb_cyc_i=0 → mode_q ← mode_sel_i (if legal). cyc&stb&~ack → ACTIVE. cyc&stb&ack → stay IDLE.
  - ACTIVE: ack → IDLE; wb_cyc_i dropped by master → IDLE (abandoned); timeout → ABORT.
  - ABORT: all s_cyc/s_stb forced 0; leave to IDLE when wb_cyc_i=0.
- mode_q updates only when state=IDLE and wb_cyc_i=0; a request arriving during a cycle is re-sampled later.
- busy_o = (state != IDLE).

## Timing
- Reset values: mode_q=RESET_MODE, state=IDLE, counter=0, wb_err_o=0, busy_o=0; strobe outputs follow inputs combinationally (zero if master idle).
- Mode latency: mode_sel_i change in idle cycle k → mode_o and routing switch at cycle k+1.
- Ack latency: zero added cycles; router is transparent in data path.
- Timeout counter: clears on ack or leaving ACTIVE; increments each ACTIVE cycle. wb_err_o pulses exactly one cycle when count reaches TIMEOUT-1 (i.e. TIMEOUT cycles after stb with no ack); ack on that same cycle wins (no err).
- Slave ack in ABORT: discarded, never reaches wb_ack_o.
- Reset mid-transfer: state → IDLE, mode_q → RESET_MODE next edge regardless of wb_cyc_i.

## Configuration
- IRDA_WB_ROUTER_TIMEOUT_EN defined: counter, ABORT state and wb_err_o active as above.
- Undefined: no counter, ABORT unreachable, wb_err_o tied 0; ACTIVE waits indefinitely for ack or cyc drop.

## Structure
- Package irda_wb_pkg: FSM state enum (IDLE/ACTIVE/ABORT), mode encoding constants (MODE_SIR=0, MODE_MIR=1, MODE_FIR=2), default DW/AW.
- Sub-module irda_wb_timeout: clear/enable-driven counter with one-cycle expiry pulse; instantiated only under the macro.

## Test plan
- NCH=3, mode 1, write 32'hA5A5_0001 @ adr 2, s_ack_i[1] at 3rd cycle → only s_stb_o[1]=1, wb_ack_o 3 cycles after stb, channels 0/2 outputs all zero.
- mode_sel_i 0→2 while busy_o=1 → mode_o stays 0 until cycle after wb_cyc_i falls, then 2.
- WP_MASK bit 0, mode 0, write @ adr 4'h8 → s_we_o[0]=0, s_stb_o[0]=1; write @ 4'h3 → s_we_o[0]=1.
- Read, s_dat_i[2]=32'h1234_5678 with ack → wb_dat_o=32'h1234_5678 same cycle.
- Macro on, TIMEOUT=16, no ack → wb_err_o one pulse 16 cycles after stb; late s_ack_i ignored; strobes 0 until cyc drops.
- wb_rst_i high during ACTIVE with mode 2, RESET_MODE=0 → next cycle busy_o=0, mode_o=0, wb_err_o=0.
